tff_count_ctrl: RTL

Sequencing controller for a bank of toggle flip-flops used as a programmable synchronous up/down counter. It computes the per-bit toggle enables each cycle to load, count up, count down, hold or auto-reload. It runs a start/stop/done handshake so a host FSM can launch timed intervals. It sits between the host control logic and the T-flip-flop storage, and owns every toggle decision.

---
 rtl/tff_count_ctrl_pkg.sv | 14 +
 rtl/tff_count_ctrl_tff_bank.sv | 20 ++
 rtl/tff_count_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/tff_count_ctrl_pkg.sv
// Shared definitions for the toggle-flip-flop counter controller:
// FSM state encoding and the supported counter width range.
package tff_count_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 16;

endpackage

// File: rtl/tff_count_ctrl_tff_bank.sv
// Bank of WIDTH toggle flip-flops. Each bit inverts on an edge where its T is 1;
// this is the only storage of the counter value.
module tff_bank #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/tff_count_ctrl.sv
// Controller for a T-flip-flop up/down counter: start/stop/done handshake,
// launch-time capture of the run settings, and every per-bit toggle decision.
//
// state   | meaning
// IDLE    | counter holds, waiting for start
// RUN     | counting toward term_cap (reloads or finishes on match)
// DONE    | one-cycle completion of a one-shot run
module tff_count_ctrl
  import tff_count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             up,
  input  logic             reload,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("tff_count_ctrl: WIDTH out of supported range");
  end

  state_t           state_q;
  state_t           state_d;
  logic             up_q;
  logic             reload_q;
  logic [WIDTH-1:0] load_q;
  logic [WIDTH-1:0] term_q;
  logic             capture;
  logic             tc_d;
  logic             tc_q;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic [WIDTH-1:0] lo;
  logic             match;

  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .t     (t),
    .q     (q)
  );

  assign match = (q == term_q);

  // Bit i toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
  always_comb begin
    t_up = '0;
    t_dn = '0;
    lo   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lo      = (WIDTH'(1) << i) - WIDTH'(1);
      t_up[i] = ((q & lo) == lo);
      t_dn[i] = ((q & lo) == '0);
    end
  end

  always_comb begin
    state_d = state_q;
    t       = '0;
    capture = 1'b0;
    tc_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          t       = q ^ load_val;
          capture = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (match && reload_q) begin
          t    = q ^ load_q;
          tc_d = 1'b1;
        end else if (match) begin
          state_d = ST_DONE;
        end else begin
          t = up_q ? t_up : t_dn;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tc_q     <= 1'b0;
      up_q     <= 1'b0;
      reload_q <= 1'b0;
      load_q   <= '0;
      term_q   <= '0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      if (capture) begin
        up_q     <= up;
        reload_q <= reload;
        load_q   <= load_val;
        term_q   <= term_val;
      end
    end
  end

  assign count = q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign tc    = tc_q;

endmodule
